// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage.
// Holds the PC and drives it to instruction memory. It captures the returned
// word into a one-entry decode slot, stalls on decode back-pressure, and
// redirects on a taken branch or jump.
//
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   instr_raddr          - fetch byte address (the PC register)
//   instr_code           - combinational read data for instr_raddr
//   redirect             - taken branch/jump strobe; redirect_addr is its target
//   id_ready             - decode accepts the held instruction this cycle
//   id_valid             - the decode slot holds a valid instruction
//   id_instr, id_pc      - the held instruction word and its address
//   id_pc_plus4          - id_pc + 4, wrapping modulo 2^32
//   fetch_cnt            - number of instructions accepted by decode
//   instr_misalign       - high while halted on a misaligned target
//                          (only present with FETCH_MISALIGN_TRAP_EN)
//
// Build option: FETCH_MISALIGN_TRAP_EN
//   Defined:   a misaligned redirect loads its target unmodified and halts.
//   Undefined: redirect targets are forced to word alignment.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_raddr,
    input  logic [31:0] instr_code,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        instr_misalign,
`endif
    output logic [31:0] fetch_cnt
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   target;
    logic              target_halt;

    assign instr_raddr = pc;

    // Redirect target and whether taking it parks the stage in HALT.
    always_comb begin
        target      = redirect_addr & ~XLEN'(3);
        target_halt = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        target      = redirect_addr;
        target_halt = |redirect_addr[1:0];
`endif
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign instr_misalign = (state == HALT);
`endif

    // Fetch state machine, PC and decode slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= NOP_INSTR;
            id_pc       <= RESET_PC;
            id_pc_plus4 <= RESET_PC + XLEN'(4);
            fetch_cnt   <= '0;
        end else begin
            // Acceptance is counted unless a redirect squashes the slot.
            if (id_valid && id_ready && !redirect) begin
                fetch_cnt <= fetch_cnt + XLEN'(1);
            end

            if (redirect) begin
                // Redirect wins over stall and advance in every state.
                pc       <= target;
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
                state    <= target_halt ? HALT : FETCH;
            end else begin
                unique case (state)
                    BOOT: begin
                        state <= FETCH;
                    end
                    FETCH: begin
                        if (!id_valid || id_ready) begin
                            id_instr    <= instr_code;
                            id_pc       <= pc;
                            id_pc_plus4 <= pc + XLEN'(4);
                            id_valid    <= 1'b1;
                            pc          <= pc + XLEN'(4);
                        end
                    end
                    HALT: begin
                        state <= HALT;
                    end
                    default: begin
                        state <= BOOT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level
// model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        id_ready;

    logic [31:0] instr_raddr, instr_code;
    logic        id_valid;
    logic [31:0] id_instr, id_pc, id_pc_plus4, fetch_cnt;
    logic        misalign;

    logic [31:0] raddr2, code2, instr2, pc2, plus4_2, cnt2;
    logic        valid2;
    logic        misalign2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction memory contents: two pinned words, the rest address-derived.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0041_82b3;
        if (a == 32'h0000_0050) return 32'h0021_2a03;
        return a ^ 32'h1357_9bdf;
    endfunction

    assign instr_code = rom_word(instr_raddr);
    assign code2      = rom_word(raddr2);

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .instr_raddr(instr_raddr), .instr_code(instr_code),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .id_ready(id_ready), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
`ifdef FETCH_MISALIGN_TRAP_EN
        .instr_misalign(misalign),
`endif
        .fetch_cnt(fetch_cnt)
    );

    // Second instance exercising PC wrap from the top of the address space.
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset),
        .instr_raddr(raddr2), .instr_code(code2),
        .redirect(1'b0), .redirect_addr(32'h0),
        .id_ready(1'b1), .id_valid(valid2),
        .id_instr(instr2), .id_pc(pc2), .id_pc_plus4(plus4_2),
`ifdef FETCH_MISALIGN_TRAP_EN
        .instr_misalign(misalign2),
`endif
        .fetch_cnt(cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: next fetch address, one decode slot, acceptance count.
    bit          m_init = 0;
    bit          m_boot, m_halt, m_valid;
    logic [31:0] m_pc, m_instr, m_idpc, m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1; m_boot = 1; m_halt = 0; m_valid = 0;
            m_pc = 32'h0; m_instr = NOP; m_idpc = 32'h0; m_cnt = 0;
        end else if (m_init) begin
            if (m_valid && id_ready && !redirect) m_cnt = m_cnt + 1;
            if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                m_pc   = redirect_addr;
                m_halt = (redirect_addr % 4) != 0;
`else
                m_pc   = (redirect_addr / 4) * 4;
                m_halt = 0;
`endif
                m_boot = 0; m_valid = 0; m_instr = NOP;
            end else if (m_boot) begin
                m_boot = 0;
            end else if (!m_halt && (!m_valid || id_ready)) begin
                m_instr = rom_word(m_pc);
                m_idpc  = m_pc;
                m_valid = 1;
                m_pc    = m_pc + 4;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            chk("instr_raddr", instr_raddr, m_pc);
            chk("id_valid", 32'(id_valid), 32'(m_valid));
            chk("id_instr", id_instr, m_instr);
            chk("id_pc", id_pc, m_idpc);
            chk("id_pc_plus4", id_pc_plus4, m_idpc + 32'd4);
            chk("fetch_cnt", fetch_cnt, m_cnt);
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("instr_misalign", 32'(misalign), 32'(m_halt));
`endif
        end
    end

    initial begin
        reset = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_addr = 32'h0;
        step(); step();
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr, NOP);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_raddr", instr_raddr, 32'd0);
        chk("rst_raddr2", raddr2, 32'hFFFF_FFFC);

        reset = 1'b0;
        step();
        chk("boot_valid", 32'(id_valid), 32'd0);
        step();
        chk("first_valid", 32'(id_valid), 32'd1);
        chk("first_instr", id_instr, 32'h0041_82b3);
        chk("first_pc", id_pc, 32'h0);
        chk("first_plus4", id_pc_plus4, 32'h4);
        chk("wrap_pc_a", pc2, 32'hFFFF_FFFC);
        chk("wrap_plus4", plus4_2, 32'h0);
        step();
        chk("seq_pc4", id_pc, 32'h4);
        chk("wrap_pc_b", pc2, 32'h0);
        step();
        chk("seq_pc8", id_pc, 32'h8);
        chk("seq_cnt2", fetch_cnt, 32'd2);

        id_ready = 1'b0;
        repeat (3) step();
        chk("stall_pc", id_pc, 32'h8);
        chk("stall_cnt", fetch_cnt, 32'd2);
        id_ready = 1'b1;
        step();
        chk("unstall_pc", id_pc, 32'hC);
        chk("unstall_cnt", fetch_cnt, 32'd3);

        id_ready = 1'b0; redirect = 1'b1; redirect_addr = 32'h50;
        step();
        chk("redir_valid", 32'(id_valid), 32'd0);
        chk("redir_instr", id_instr, NOP);
        redirect = 1'b0; id_ready = 1'b1;
        step();
        chk("target_valid", 32'(id_valid), 32'd1);
        chk("target_pc", id_pc, 32'h50);
        chk("target_instr", id_instr, 32'h0021_2a03);

        redirect = 1'b1; redirect_addr = 32'h52;
        step();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_raddr", instr_raddr, 32'h52);
        step(); step();
        chk("halt_valid", 32'(id_valid), 32'd0);
        chk("halt_flag", 32'(misalign), 32'd1);
        redirect = 1'b1; redirect_addr = 32'h10;
        step();
        redirect = 1'b0;
        chk("unhalt_flag", 32'(misalign), 32'd0);
        step();
        chk("unhalt_pc", id_pc, 32'h10);
`else
        chk("mis_raddr", instr_raddr, 32'h50);
        step();
        chk("mis_pc", id_pc, 32'h50);
`endif
        chk("mis_cnt", fetch_cnt, 32'd3);
        step(); step();
        id_ready = 1'b0;
        step();
        chk("pre_rst_cnt", fetch_cnt, 32'd5);
        reset = 1'b1;
        step();
        chk("mid_rst_cnt", fetch_cnt, 32'd0);
        chk("mid_rst_valid", 32'(id_valid), 32'd0);
        chk("mid_rst_instr", id_instr, 32'h0000_0013);
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            id_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: redirect_addr = $urandom_range(0, 255);
                1: redirect_addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                default: redirect_addr = $urandom;
            endcase
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h0000_0013 (ADDI x0,x0,0), the value of id_instr when no instruction is held.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port instr_raddr, output, 32, the byte address driven to instruction_memory.
REQ-006 SHALL have port instr_code, input, 32, the combinational read data returned from instruction_memory for instr_raddr.
REQ-007 SHALL have port redirect, input, 1, the branch/jump taken strobe.
REQ-008 SHALL have port redirect_addr, input, 32, the branch/jump target byte address.
REQ-009 SHALL have port id_ready, input, 1, which is high when decode accepts id_instr this cycle.
REQ-010 SHALL have port id_valid, output, 1, which is high when id_instr/id_pc hold a valid fetched instruction.
REQ-011 SHALL have port id_instr, output, 32, the fetched instruction word.
REQ-012 SHALL have port id_pc, output, 32, the address of id_instr.
REQ-013 SHALL have port id_pc_plus4, output, 32, equal to id_pc+4 (mod 2^32).
REQ-014 SHALL have port fetch_cnt, output, 32, the count of instructions accepted by decode.

Function
REQ-015 SHALL implement FSM states BOOT, FETCH, HALT; BOOT→FETCH unconditionally after one cycle.
REQ-016 SHALL drive instr_raddr = pc register combinationally in all states.
REQ-017 In FETCH, "advance" = (!id_valid || id_ready) && !redirect; on advance it SHALL load id_instr<=instr_code, id_pc<=pc, id_valid<=1, pc<=pc+4.
REQ-018 In FETCH with id_valid=1, id_ready=0 and no redirect, the block SHALL hold pc, id_instr and id_pc unchanged (stall).
REQ-019 redirect=1 SHALL take priority over stall/advance in every state: pc<=redirect_addr, id_valid<=0, id_instr<=NOP_INSTR; the first target instruction appears with id_valid=1 one cycle later.
REQ-020 fetch_cnt SHALL increment by 1 on every cycle with id_valid && id_ready && !redirect, wrapping from 32'hFFFF_FFFF to 0.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000) without flags.
REQ-022 In BOOT, id_valid SHALL be 0 and pc SHALL NOT change unless redirect=1.
REQ-023 In HALT, id_valid SHALL be 0 and pc SHALL be held; only an aligned redirect or reset exits HALT (to FETCH).

Reset
REQ-024 On reset=1 at a clock edge: state<=BOOT, pc<=RESET_PC, id_valid<=0, id_instr<=NOP_INSTR, id_pc<=RESET_PC, fetch_cnt<=0; reset SHALL override redirect.
REQ-025 Reset asserted mid-stall or mid-redirect SHALL discard the held instruction and pending target.
REQ-026 First valid instruction SHALL appear with id_valid=1 two edges after reset deasserts (BOOT, then one FETCH advance).

Configuration
REQ-027 Macro FETCH_MISALIGN_TRAP_EN SHALL select misalignment handling for redirect_addr[1:0]!=0.
REQ-028 With FETCH_MISALIGN_TRAP_EN defined: a misaligned redirect SHALL load pc<=redirect_addr unmodified, enter HALT, and drive an extra output instr_misalign (1 bit) high for as long as the block is in HALT.
REQ-029 Without FETCH_MISALIGN_TRAP_EN: the port instr_misalign SHALL NOT exist, HALT SHALL be unreachable, and redirect SHALL load pc<={redirect_addr[31:2],2'b00}.

Verification
REQ-030 Reset, ROM word0=32'h004182b3, id_ready=1 → edge 2 after release: id_valid=1, id_instr=32'h004182b3, id_pc=0, id_pc_plus4=4; subsequent edges give id_pc=4,8,12.
REQ-031 id_ready=0 for 3 cycles while id_pc=8 → id_instr/id_pc held at 8, fetch_cnt frozen; id_ready=1 → id_pc=12 next edge.
REQ-032 redirect=1, redirect_addr=32'h0000_0050 with id_ready=0 → next edge id_valid=0; following edge id_pc=32'h50, id_instr=ROM word 20 (32'h00212a03).
REQ-033 RESET_PC=32'hFFFF_FFFC, id_ready=1 → id_pc sequence FFFF_FFFC then 0000_0000.
REQ-034 redirect_addr=32'h0000_0052: with macro → HALT, instr_misalign=1, id_valid=0 until a redirect to 32'h0000_0010; without macro → pc=32'h50.
REQ-035 Assert reset during a stall with fetch_cnt=5 → next edge fetch_cnt=0, id_valid=0, id_instr=32'h0000_0013.
